fetch_icache: RTL
=================

Name: fetch_icache

Overview:
Parametrised instruction-fetch stage with an integrated direct-mapped instruction cache.
- Holds the PC and presents one instruction per cycle on a hit.
- Supports branch redirect and pipeline stall.
- Refills whole cache lines from a simple burst memory interface on a miss.
- Sits at the head of the pipeline, feeding the decode stage.

Parameters:
ADDR_WIDTH, 64, PC/branch/memory address width in bits
INSTR_WIDTH, 32, instruction width in bits (multiple of 8); INSTR_BYTES = INSTR_WIDTH/8
LINES, 16, number of cache lines (power of 2, >=2)
WORDS_PER_LINE, 4, instructions per line (power of 2, >=2)
RESET_PC, 0, PC value after reset (INSTR_BYTES-aligned)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
branch_target  in  ADDR_WIDTH  redirect address
pc_source  in  1  1 = load branch_target into PC at next edge
stall  in  1  1 = hold PC (downstream not ready)
pc  out  ADDR_WIDTH  address of current instruction
next_pc  out  ADDR_WIDTH  pc + INSTR_BYTES, combinational
instruction  out  INSTR_WIDTH  cached word at pc; 0 when hit=0
hit  out  1  pc found in cache this cycle (combinational lookup)
instr_valid  out  1  hit & state==LOOKUP
mem_req  out  1  refill request, high for the whole refill
mem_addr  out  ADDR_WIDTH  line-aligned refill base address, stable while mem_req=1
mem_rvalid  in  1  one refill beat present on mem_rdata
mem_rdata  in  INSTR_WIDTH  refill beat, delivered in ascending word order

Behaviour:
Reset:
- Single clock, one domain; reset is asynchronous and active-low on reset_n.
- While reset_n=0: pc=RESET_PC, all valid bits cleared, state=LOOKUP, mem_req=0, beat counter=0.
- Consequently hit=0, instr_valid=0, instruction=0.

Address split (pc):
- offset = low log2(INSTR_BYTES) bits (ignored).
- word = next log2(WORDS_PER_LINE) bits.
- index = next log2(LINES) bits.
- tag = remaining upper bits.

Cache storage: per line, valid bit, tag, and WORDS_PER_LINE data words.

State LOOKUP:
- hit = valid[index] & tag match.
- At the edge, pc_source=1: pc <= branch_target with offset bits forced to 0. This happens regardless of hit or stall; redirect has priority over stall.
- Else if hit & !stall: pc <= next_pc.
- Else if hit & stall: pc holds.
- Else (miss): pc holds, mem_addr <= pc with word and offset bits zeroed, mem_req <= 1, state -> REFILL.

State REFILL:
- instr_valid=0; hit is still computed but is not qualified.
- Each mem_rvalid=1 writes mem_rdata to data[line][beat] and increments beat.
- Last beat (beat==WORDS_PER_LINE-1): write tag, set valid, beat<=0, mem_req<=0, state -> LOOKUP.
- pc_source=1 during REFILL: pc <= branch_target (aligned). The refill still completes and fills its line. The next LOOKUP uses the new pc.
- stall has no effect in REFILL.
- mem_rvalid while in LOOKUP is ignored.

Latency:
- Miss detected at cycle 0 edge; mem_req=1 from cycle 1.
- With beats arriving back-to-back on cycles 1..WORDS_PER_LINE, the line is valid and hit=1 in cycle WORDS_PER_LINE+1.

Eviction: a miss to an occupied index overwrites that line. Valid is set only after the final beat.

Wrap-around: next_pc is computed modulo 2^ADDR_WIDTH; all-ones aligned pc + INSTR_BYTES = 0.

Reset mid-refill: the refill is aborted immediately; mem_req drops asynchronously and the partial line is invalid.

Test Plan:
- Cold start, RESET_PC=0, mem returns 0x11,0x22,0x33,0x44 on cycles 1-4 -> mem_req high cycles 1-4, mem_addr=0; cycle 5 hit=1, instruction=0x11; then pc 4,8,12 give 0x22,0x33,0x44 on consecutive cycles.
- After the first line is filled, pc=0x10 misses -> mem_addr=0x10; after refill, line 1 is valid and pc=0 still hits.
- Branch: during a hit at pc=0x4 with pc_source=1, branch_target=0x2 -> pc=0x0 next cycle; stall=1 also held -> pc still loads 0x0.
- Stall: stall=1 for 3 cycles at pc=0x8 -> pc, instruction (0x33) and instr_valid=1 stay constant; on release, pc=0xC.
- Redirect during refill: pc_source=1, branch_target=0x0 on the 2nd beat of a refill at 0x40 -> refill completes; pc=0x0 hits next; a later access to 0x40 hits without mem_req.
- Conflict and reset: access 0x0 then 0x100 (LINES=16, WPL=4) -> 0x100 evicts index 0 and a revisit of 0x0 misses again; reset_n=0 mid-refill -> mem_req=0 immediately; after release pc=RESET_PC and hit=0.

Source files
------------

// File: rtl/fetch_icache_if.sv
// Refill bus between the fetch stage and the backing instruction memory.
// The cache is the master: it raises mem_req with a line-aligned mem_addr and
// the memory answers with one beat per mem_rvalid in ascending word order.
interface fetch_icache_if #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32
);
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_rvalid;
    logic [INSTR_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/fetch_icache.sv
// Instruction-fetch stage with a direct-mapped instruction cache.
// Holds the PC, delivers one instruction per cycle on a hit, and on a miss
// refills the whole line over the burst bus before resuming lookup.
module fetch_icache #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    INSTR_WIDTH    = 32,
    parameter int                    LINES          = 16,
    parameter int                    WORDS_PER_LINE = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   pc_source,
    input  logic                   stall,
    output logic [ADDR_WIDTH-1:0]  pc,
    output logic [ADDR_WIDTH-1:0]  next_pc,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   hit,
    output logic                   instr_valid,
    fetch_icache_if.master         mem
);

    localparam int INSTR_BYTES = INSTR_WIDTH / 8;
    localparam int OFF_W       = $clog2(INSTR_BYTES);
    localparam int WORD_W      = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W     = $clog2(LINES);
    localparam int TAG_LSB     = OFF_W + WORD_W + INDEX_W;
    localparam int TAG_W       = ADDR_WIDTH - TAG_LSB;

    localparam logic [ADDR_WIDTH-1:0] INSTR_MASK = ADDR_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ADDR_WIDTH'(INSTR_BYTES * WORDS_PER_LINE - 1);
    localparam logic [WORD_W-1:0]     LAST_BEAT  = WORD_W'(WORDS_PER_LINE - 1);

    localparam logic [0:0] LOOKUP = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]             state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [WORD_W-1:0]      beat_q;
    logic [LINES-1:0]       valid_q;
    logic                   mem_req_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [INSTR_WIDTH-1:0] data_q [LINES][WORDS_PER_LINE];

    logic [WORD_W-1:0]      pc_word;
    logic [INDEX_W-1:0]     pc_index;
    logic [TAG_W-1:0]       pc_tag;
    logic [INDEX_W-1:0]     refill_index;
    logic [TAG_W-1:0]       refill_tag;
    logic [ADDR_WIDTH-1:0]  aligned_target;
    logic                   refill_beat;
    logic                   last_beat;

    // Address decomposition for the lookup (pc) and for the line being refilled.
    assign pc_word        = pc_q[OFF_W +: WORD_W];
    assign pc_index       = pc_q[OFF_W + WORD_W +: INDEX_W];
    assign pc_tag         = pc_q[ADDR_WIDTH-1:TAG_LSB];
    assign refill_index   = mem_addr_q[OFF_W + WORD_W +: INDEX_W];
    assign refill_tag     = mem_addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign aligned_target = branch_target & ~INSTR_MASK;
    assign refill_beat    = (state_q == REFILL) && mem.mem_rvalid;
    assign last_beat      = refill_beat && (beat_q == LAST_BEAT);

    // Combinational lookup; instruction is forced to zero whenever there is no hit.
    assign hit         = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign instruction = hit ? data_q[pc_index][pc_word] : '0;
    assign instr_valid = hit && (state_q == LOOKUP);
    assign pc          = pc_q;
    assign next_pc     = pc_q + ADDR_WIDTH'(INSTR_BYTES);
    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;

    // Control: PC sequencing, redirect, miss detection and refill bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= LOOKUP;
            pc_q       <= RESET_PC;
            beat_q     <= '0;
            valid_q    <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                LOOKUP: begin
                    if (pc_source) begin
                        pc_q <= aligned_target;
                    end else if (hit && !stall) begin
                        pc_q <= next_pc;
                    end else if (!hit) begin
                        mem_addr_q        <= pc_q & ~LINE_MASK;
                        mem_req_q         <= 1'b1;
                        valid_q[pc_index] <= 1'b0;
                        state_q           <= REFILL;
                    end
                end
                REFILL: begin
                    if (pc_source) begin
                        pc_q <= aligned_target;
                    end
                    if (refill_beat) begin
                        beat_q <= beat_q + 1'b1;
                        if (last_beat) begin
                            beat_q                <= '0;
                            mem_req_q             <= 1'b0;
                            valid_q[refill_index] <= 1'b1;
                            state_q               <= LOOKUP;
                        end
                    end
                end
                default: state_q <= LOOKUP;
            endcase
        end
    end

    // Line storage: each beat lands in the refill line; the tag is written with the last beat.
    always_ff @(posedge clock) begin
        if (refill_beat) begin
            data_q[refill_index][beat_q] <= mem.mem_rdata;
            if (last_beat) begin
                tag_q[refill_index] <= refill_tag;
            end
        end
    end

endmodule
